// File: rtl/rice_core_writeback_stage.sv
// Register-file write stage: arbitrates EX results against queued LSU results
// and tracks outstanding long-latency destinations. Optional: RICE_WB_LSU_BYPASS_EN.
`timescale 1ns/1ps
module rice_core_writeback_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_ex_valid,
    input  logic [4:0]                             i_ex_rd,
    input  logic [XLEN-1:0]                        i_ex_value,
    input  logic                                   i_lsu_valid,
    output logic                                   o_lsu_ready,
    input  logic [4:0]                             i_lsu_rd,
    input  logic [XLEN-1:0]                        i_lsu_value,
    input  logic                                   i_issue_valid,
    input  logic [4:0]                             i_issue_rd,
    output logic                                   o_wb_valid,
    output logic [4:0]                             o_wb_rd,
    output logic [XLEN-1:0]                        o_wb_value,
    output logic [31:0]                            o_pending,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]       o_queue_count
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);

    logic [4:0]      r_q_rd  [QUEUE_DEPTH];
    logic [XLEN-1:0] r_q_val [QUEUE_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_wb_valid;
    logic            r_wb_lsu;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_value;
    logic [31:0]     r_pending;

    logic            w_ex_take;
    logic            w_fifo_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_bypass;
    logic            w_enq;
    logic [31:0]     w_set;
    logic [31:0]     w_clr;

    // Ready depends on occupancy only, so a full queue never accepts push-through.
    assign o_lsu_ready   = (r_count != CW'(QUEUE_DEPTH));
    assign o_wb_valid    = r_wb_valid;
    assign o_wb_rd       = r_wb_rd;
    assign o_wb_value    = r_wb_value;
    assign o_pending     = r_pending;
    assign o_queue_count = r_count;

    always_comb begin
        w_ex_take    = i_ex_valid && (i_ex_rd != 5'd0);
        w_fifo_empty = (r_count == '0);
        w_push       = i_lsu_valid && o_lsu_ready;
        w_pop        = !w_ex_take && !w_fifo_empty;
`ifdef RICE_WB_LSU_BYPASS_EN
        w_bypass     = w_push && w_fifo_empty && !w_ex_take;
`else
        w_bypass     = 1'b0;
`endif
        w_enq        = w_push && !w_bypass;
        w_set        = '0;
        w_clr        = '0;
        if (i_issue_valid) begin
            w_set = 32'(1) << i_issue_rd;
        end
        // A load's bit clears on the edge that commits it to the register file.
        if (r_wb_valid && r_wb_lsu) begin
            w_clr = 32'(1) << r_wb_rd;
        end
    end

    // Queue storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_q_rd[r_wr_ptr]  <= i_lsu_rd;
            r_q_val[r_wr_ptr] <= i_lsu_value;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write port: EX first, then queue head, then (optionally) a bypassed LSU result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wb_valid <= 1'b0;
            r_wb_lsu   <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_value <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_lsu   <= 1'b0;
            if (w_ex_take) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= i_ex_rd;
                r_wb_value <= i_ex_value;
            end else if (w_pop) begin
                r_wb_valid <= (r_q_rd[r_rd_ptr] != 5'd0);
                r_wb_lsu   <= 1'b1;
                r_wb_rd    <= r_q_rd[r_rd_ptr];
                r_wb_value <= r_q_val[r_rd_ptr];
            end else if (w_bypass) begin
                r_wb_valid <= (i_lsu_rd != 5'd0);
                r_wb_lsu   <= 1'b1;
                r_wb_rd    <= i_lsu_rd;
                r_wb_value <= i_lsu_value;
            end
        end
    end

    // Set beats clear for the same register; x0 never pends.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= ((r_pending & ~w_clr) | w_set) & ~32'h1;
        end
    end

    assert property (@(posedge i_clk) disable iff (i_rst)
        (i_issue_valid && (i_issue_rd != 5'd0)) |-> (!r_pending[i_issue_rd] || w_clr[i_issue_rd]))
        else $error("issue to register x%0d that already has a load in flight", i_issue_rd);

endmodule
